// File: rtl/debugport_bus_master_pkg.sv
// Shared types and widths for the debug-port bus master.
package debugport_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

endpackage

// File: rtl/debugport_bus_master_if.sv
// Host command/response channels plus the req/gnt/rvalid data bus.
// The master modport is the bus-master view; slave is the host/responder side.
interface debugport_bus_master_if;
    import debugport_bus_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [BE_W-1:0]   cmd_be;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic              data_req;
    logic              data_we;
    logic [BE_W-1:0]   data_be;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_gnt;
    logic              data_rvalid;
    logic [DATA_W-1:0] data_rdata;
    logic              data_err;

    modport master (
        input  cmd_valid, cmd_we, cmd_be, cmd_addr, cmd_wdata, rsp_ready,
        input  data_gnt, data_rvalid, data_rdata, data_err,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output data_req, data_we, data_be, data_addr, data_wdata
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_be, cmd_addr, cmd_wdata, rsp_ready,
        output data_gnt, data_rvalid, data_rdata, data_err,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  data_req, data_we, data_be, data_addr, data_wdata
    );

endinterface

// File: rtl/debugport_bus_master.sv
// Debug-port bus master: turns one host command into one req/gnt/rvalid
// bus transaction and returns the result on the response channel.
// Optional feature: define DBGBUS_TIMEOUT_EN to abort transactions that
// get no gnt/rvalid within TIMEOUT_CYCLES cycles of req rising.
module debugport_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    debugport_bus_master_if.master bus
);
    import debugport_bus_pkg::*;

    state_e            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              data_req_q, data_req_d;
    logic              data_we_q, data_we_d;
    logic [BE_W-1:0]   data_be_q, data_be_d;
    logic [ADDR_W-1:0] data_addr_q, data_addr_d;
    logic [DATA_W-1:0] data_wdata_q, data_wdata_d;

    logic accept;
    logic capture;
    logic expire;
    logic timeout_hit;

    assign accept = (state_q == IDLE) && bus.cmd_valid && cmd_ready_q;

`ifdef DBGBUS_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rsp_timeout_q, rsp_timeout_d;

    // Cycles spent in REQ/WAIT since the command was accepted.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (accept) begin
            tmo_cnt_d = '0;
        end else if (state_q == REQ || state_q == WAIT) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Timeout flag follows the kind of response being produced.
    always_comb begin
        rsp_timeout_d = rsp_timeout_q;
        if (capture) begin
            rsp_timeout_d = 1'b0;
        end else if (expire) begin
            rsp_timeout_d = 1'b1;
        end
    end

    // Counter and timeout flag registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt_q     <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign timeout_hit     = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus.rsp_timeout = rsp_timeout_q;
`else
    assign timeout_hit     = 1'b0;
    assign bus.rsp_timeout = 1'b0;
`endif

    // Transaction sequencing: one outstanding bus access at a time.
    always_comb begin
        state_d      = state_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        data_req_d   = data_req_q;
        data_we_d    = data_we_q;
        data_be_d    = data_be_q;
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;
        capture      = 1'b0;
        expire       = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = REQ;
                    data_req_d   = 1'b1;
                    data_we_d    = bus.cmd_we;
                    data_be_d    = bus.cmd_be;
                    data_addr_d  = {bus.cmd_addr[ADDR_W-1:2], 2'b00};
                    data_wdata_d = bus.cmd_wdata;
                end
            end
            REQ: begin
                // A grant wins over a timeout on the same edge; rvalid alongside
                // the grant completes the access immediately.
                if (bus.data_gnt) begin
                    data_req_d = 1'b0;
                    state_d    = WAIT;
                    capture    = bus.data_rvalid;
                end else begin
                    expire = timeout_hit;
                end
            end
            WAIT: begin
                if (bus.data_rvalid) begin
                    capture = 1'b1;
                end else begin
                    expire = timeout_hit;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = data_we_q ? '0 : bus.data_rdata;
            rsp_err_d   = bus.data_err;
        end else if (expire) begin
            state_d     = RESP;
            data_req_d  = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
        end

        cmd_ready_d = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            data_req_q   <= 1'b0;
            data_we_q    <= 1'b0;
            data_be_q    <= '0;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            data_req_q   <= data_req_d;
            data_we_q    <= data_we_d;
            data_be_q    <= data_be_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.data_req   = data_req_q;
    assign bus.data_we    = data_we_q;
    assign bus.data_be    = data_be_q;
    assign bus.data_addr  = data_addr_q;
    assign bus.data_wdata = data_wdata_q;

endmodule

// File: tb/tb_debugport_bus_master.sv
// Bench for debugport_bus_master: a cycle-driven responder inside each
// transaction plus expectations computed from the protocol rules.
module tb_debugport_bus_master;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    debugport_bus_master_if dbg();

`ifdef DBGBUS_TIMEOUT_EN
    localparam int TMO = 16;
    debugport_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .bus(dbg.master));
`else
    debugport_bus_master dut (.clk(clk), .rst(rst), .bus(dbg.master));
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Observations from one transaction.
    int          o_lat, o_req, o_gnts;
    bit          o_stable, o_hold_ok;
    logic        o_we, o_err, o_tmo, o_ready_after;
    logic [3:0]  o_be;
    logic [31:0] o_addr, o_wdata, o_rdata;

    // Issue one command and act as the bus responder until the response is consumed.
    // g: req cycles seen before gnt is driven (1 = nominal), rv: cycles from gnt to rvalid,
    // same: rvalid together with gnt, hold: cycles rsp_ready is withheld with cmd_valid high.
    task automatic do_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                          input int g, input int rv, input bit same, input int hold);
        int  req_seen = 0;
        int  rv_cnt = 0;
        bit  rv_pend = 0;
        bit  first = 1;
        o_lat = -1; o_req = 0; o_gnts = 0; o_stable = 1; o_hold_ok = 1;
        o_we = 0; o_be = 0; o_addr = 0; o_wdata = 0; o_rdata = 0; o_err = 0; o_tmo = 0;
        o_ready_after = 1'bx;
        dbg.cmd_valid = 1; dbg.cmd_we = we; dbg.cmd_be = be;
        dbg.cmd_addr = addr; dbg.cmd_wdata = wdata; dbg.rsp_ready = 0;
        @(posedge clk);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            dbg.cmd_valid = 0;
            if (dbg.rsp_valid) begin
                o_lat = k - 1; o_rdata = dbg.rsp_rdata; o_err = dbg.rsp_err; o_tmo = dbg.rsp_timeout;
                break;
            end
            if (dbg.data_req) begin
                o_req++;
                if (first) begin
                    first = 0; o_we = dbg.data_we; o_be = dbg.data_be;
                    o_addr = dbg.data_addr; o_wdata = dbg.data_wdata;
                end else if (dbg.data_we !== o_we || dbg.data_be !== o_be ||
                             dbg.data_addr !== o_addr || dbg.data_wdata !== o_wdata) begin
                    o_stable = 0;
                end
            end
            if (dbg.data_rvalid) dbg.data_rvalid = 0;
            if (dbg.data_gnt) begin
                dbg.data_gnt = 0;
                req_seen = 0;
                if (!same) begin rv_pend = 1; rv_cnt = 0; end
            end else if (dbg.data_req) begin
                req_seen++;
                if (req_seen > g) begin
                    dbg.data_gnt = 1; o_gnts++;
                    if (same) begin dbg.data_rvalid = 1; dbg.data_rdata = rdata; dbg.data_err = err; end
                end
            end
            if (rv_pend) begin
                rv_cnt++;
                if (rv_cnt >= rv) begin
                    dbg.data_rvalid = 1; dbg.data_rdata = rdata; dbg.data_err = err; rv_pend = 0;
                end
            end
        end
        dbg.data_rvalid = 0; dbg.data_gnt = 0; dbg.data_err = 0;
        if (o_lat >= 0) begin
            if (hold > 0) dbg.cmd_valid = 1;
            for (int h = 0; h < hold; h++) begin
                if (h == 0) begin
                    // Stale gnt/rvalid while the response is pending must change nothing.
                    dbg.data_gnt = 1; dbg.data_rvalid = 1; dbg.data_rdata = ~rdata; dbg.data_err = ~err;
                end
                @(posedge clk);
                @(negedge clk);
                dbg.data_gnt = 0; dbg.data_rvalid = 0; dbg.data_err = 0;
                if (dbg.cmd_ready !== 1'b0 || dbg.rsp_valid !== 1'b1 || dbg.rsp_rdata !== o_rdata ||
                    dbg.rsp_err !== o_err || dbg.data_req !== 1'b0) o_hold_ok = 0;
            end
            dbg.cmd_valid = 0;
            dbg.rsp_ready = 1;
            @(posedge clk);
            @(negedge clk);
            dbg.rsp_ready = 0;
            if (dbg.rsp_valid !== 1'b0) o_hold_ok = 0;
            o_ready_after = dbg.cmd_ready;
        end
    endtask

    task automatic test_reset();
        rst = 0;
        dbg.cmd_valid = 1; dbg.cmd_we = 1; dbg.cmd_be = 4'hF;
        dbg.cmd_addr = $urandom; dbg.cmd_wdata = $urandom;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({dbg.cmd_ready, dbg.rsp_valid, dbg.rsp_rdata, dbg.rsp_err, dbg.rsp_timeout, dbg.data_req,
             dbg.data_we, dbg.data_be, dbg.data_addr, dbg.data_wdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got req=%b rdy=%b rspv=%b addr=%h, want all zero",
                     dbg.data_req, dbg.cmd_ready, dbg.rsp_valid, dbg.data_addr);
        end
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        dbg.cmd_valid = 0;
        n_cmp++;
        if (dbg.cmd_ready !== 1'b1 || dbg.data_req !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: got cmd_ready=%b data_req=%b, want 1/0", dbg.cmd_ready, dbg.data_req);
        end
    endtask

    task automatic test_write();
        do_txn(1'b1, 4'h1, 32'h1000_0003, 32'h0000_00A5, 32'h1234_5678, 1'b0, 1, 1, 0, 0);
        n_cmp++;
        if (o_addr !== 32'h1000_0000 || o_we !== 1'b1 || o_be !== 4'h1 || o_wdata !== 32'hA5) begin
            n_bad++;
            $display("FAIL write_bus: got addr=%h we=%b be=%h wdata=%h, want 10000000/1/1/000000a5",
                     o_addr, o_we, o_be, o_wdata);
        end
        n_cmp++;
        if (o_req !== 2) begin n_bad++; $display("FAIL write_req_len: got %0d, want 2", o_req); end
        n_cmp++;
        if (o_lat !== 3) begin n_bad++; $display("FAIL write_latency: got %0d, want 3", o_lat); end
        n_cmp++;
        if (o_rdata !== 32'h0 || o_err !== 1'b0 || o_tmo !== 1'b0) begin
            n_bad++;
            $display("FAIL write_rsp: got rdata=%h err=%b tmo=%b, want 0/0/0", o_rdata, o_err, o_tmo);
        end
        n_cmp++;
        if (o_ready_after !== 1'b1) begin n_bad++; $display("FAIL write_ready_after: got %b, want 1", o_ready_after); end
    endtask

    task automatic test_read();
        do_txn(1'b0, 4'hF, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0, 1, 1, 0, 0);
        n_cmp++;
        if (o_rdata !== 32'hDEAD_BEEF || o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL read_rsp: got rdata=%h err=%b, want deadbeef/0", o_rdata, o_err);
        end
        n_cmp++;
        if (o_gnts !== 1 || o_addr !== 32'h40) begin
            n_bad++;
            $display("FAIL read_grants: got grants=%0d addr=%h, want 1/00000040", o_gnts, o_addr);
        end
    endtask

    task automatic test_error();
        do_txn(1'b0, 4'h3, 32'h2000_0010, 32'h0, 32'h0BAD_0BAD, 1'b1, 1, 1, 0, 0);
        n_cmp++;
        if (o_err !== 1'b1 || o_tmo !== 1'b0 || o_rdata !== 32'h0BAD_0BAD) begin
            n_bad++;
            $display("FAIL error_rsp: got err=%b tmo=%b rdata=%h, want 1/0/0bad0bad", o_err, o_tmo, o_rdata);
        end
    endtask

    task automatic test_hold();
        do_txn(1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 1'b0, 1, 1, 0, 10);
        n_cmp++;
        if (o_hold_ok !== 1'b1 || o_rdata !== 32'hCAFE_F00D) begin
            n_bad++;
            $display("FAIL hold_rsp: got stable=%b rdata=%h, want 1/cafef00d", o_hold_ok, o_rdata);
        end
        n_cmp++;
        if (o_ready_after !== 1'b1) begin n_bad++; $display("FAIL hold_ready_after: got %b, want 1", o_ready_after); end
        do_txn(1'b1, 4'hC, 32'h0000_0104, 32'h1111_2222, 32'h0, 1'b0, 1, 1, 0, 0);
        n_cmp++;
        if (o_lat !== 3) begin n_bad++; $display("FAIL hold_next_latency: got %0d, want 3", o_lat); end
    endtask

    task automatic test_gnt_delay();
        do_txn(1'b1, 4'h6, 32'h3000_00FE, 32'h5A5A_A5A5, 32'h0, 1'b0, 5, 1, 0, 0);
        n_cmp++;
        if (o_stable !== 1'b1 || o_addr !== 32'h3000_00FC || o_be !== 4'h6 || o_wdata !== 32'h5A5A_A5A5) begin
            n_bad++;
            $display("FAIL gntdly_stable: got stable=%b addr=%h be=%h wdata=%h, want 1/300000fc/6/5a5aa5a5",
                     o_stable, o_addr, o_be, o_wdata);
        end
        n_cmp++;
        if (o_req !== 6 || o_gnts !== 1 || o_lat !== 7) begin
            n_bad++;
            $display("FAIL gntdly_timing: got req=%0d grants=%0d lat=%0d, want 6/1/7", o_req, o_gnts, o_lat);
        end
        dbg.data_gnt = 1; dbg.data_rvalid = 1; dbg.data_rdata = $urandom; dbg.data_err = 1;
        @(posedge clk);
        @(negedge clk);
        dbg.data_gnt = 0; dbg.data_rvalid = 0; dbg.data_err = 0;
        n_cmp++;
        if (dbg.rsp_valid !== 1'b0 || dbg.data_req !== 1'b0 || dbg.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_spurious: got rsp_valid=%b data_req=%b cmd_ready=%b, want 0/0/1",
                     dbg.rsp_valid, dbg.data_req, dbg.cmd_ready);
        end
    endtask

    task automatic test_same_cycle();
        do_txn(1'b0, 4'hF, 32'h0000_0200, 32'h0, 32'h7777_8888, 1'b1, 1, 1, 1, 0);
        n_cmp++;
        if (o_lat !== 2 || o_rdata !== 32'h7777_8888 || o_err !== 1'b1 || o_gnts !== 1) begin
            n_bad++;
            $display("FAIL same_cycle: got lat=%0d rdata=%h err=%b grants=%0d, want 2/77778888/1/1",
                     o_lat, o_rdata, o_err, o_gnts);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic        we, err;
            logic [3:0]  be;
            logic [31:0] addr, wdata, rdata, exp_rdata;
            int          g, rv, hold, exp_lat;
            bit          same;
            we = 1'($urandom); err = ($urandom_range(0, 3) == 0); be = 4'($urandom);
            addr = $urandom; wdata = $urandom; rdata = $urandom;
            g = $urandom_range(1, 4); rv = $urandom_range(1, 3);
            same = ($urandom_range(0, 3) == 0); hold = $urandom_range(0, 2);
            exp_rdata = we ? 32'h0 : rdata;
            exp_lat   = same ? g + 1 : g + 1 + rv;
            do_txn(we, be, addr, wdata, rdata, err, g, rv, same, hold);
            n_cmp++;
            if (o_addr !== {addr[31:2], 2'b00} || o_we !== we || o_be !== be || o_wdata !== wdata || o_stable !== 1'b1) begin
                n_bad++;
                $display("FAIL rand_bus[%0d]: got addr=%h we=%b be=%h wdata=%h stable=%b, want %h/%b/%h/%h/1",
                         i, o_addr, o_we, o_be, o_wdata, o_stable, {addr[31:2], 2'b00}, we, be, wdata);
            end
            n_cmp++;
            if (o_lat !== exp_lat || o_req !== g + 1 || o_gnts !== 1) begin
                n_bad++;
                $display("FAIL rand_timing[%0d]: got lat=%0d req=%0d grants=%0d, want %0d/%0d/1",
                         i, o_lat, o_req, o_gnts, exp_lat, g + 1);
            end
            n_cmp++;
            if (o_rdata !== exp_rdata || o_err !== err || o_tmo !== 1'b0 || o_hold_ok !== 1'b1 || o_ready_after !== 1'b1) begin
                n_bad++;
                $display("FAIL rand_rsp[%0d]: got rdata=%h err=%b tmo=%b hold=%b rdy=%b, want %h/%b/0/1/1",
                         i, o_rdata, o_err, o_tmo, o_hold_ok, o_ready_after, exp_rdata, err);
            end
        end
    endtask

    task automatic test_reset_mid();
        dbg.cmd_valid = 1; dbg.cmd_we = 0; dbg.cmd_be = 4'hF; dbg.cmd_addr = $urandom; dbg.cmd_wdata = 0;
        @(posedge clk);
        @(negedge clk);
        dbg.cmd_valid = 0;
        dbg.data_gnt = 1;
        @(posedge clk);
        @(negedge clk);
        dbg.data_gnt = 0;
        n_cmp++;
        if (dbg.data_req !== 1'b0 || dbg.rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_wait: got data_req=%b rsp_valid=%b, want 0/0", dbg.data_req, dbg.rsp_valid);
        end
        rst = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        n_cmp++;
        if (dbg.data_req !== 1'b0 || dbg.rsp_valid !== 1'b0 || dbg.cmd_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_abort: got req=%b rspv=%b rdy=%b, want 0/0/0", dbg.data_req, dbg.rsp_valid, dbg.cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        dbg.data_rvalid = 1; dbg.data_rdata = $urandom;
        @(posedge clk);
        @(negedge clk);
        dbg.data_rvalid = 0;
        n_cmp++;
        if (dbg.rsp_valid !== 1'b0 || dbg.cmd_ready !== 1'b1 || dbg.data_req !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_stale: got rspv=%b rdy=%b req=%b, want 0/1/0", dbg.rsp_valid, dbg.cmd_ready, dbg.data_req);
        end
    endtask

`ifdef DBGBUS_TIMEOUT_EN
    task automatic test_timeout();
        do_txn(1'b0, 4'hF, 32'h4000_0008, 32'h0, 32'h9999_9999, 1'b0, 1000, 1, 0, 2);
        n_cmp++;
        if (o_lat !== TMO || o_req !== TMO || o_gnts !== 0) begin
            n_bad++;
            $display("FAIL timeout_timing: got lat=%0d req=%0d grants=%0d, want %0d/%0d/0", o_lat, o_req, o_gnts, TMO, TMO);
        end
        n_cmp++;
        if (o_err !== 1'b1 || o_tmo !== 1'b1 || o_rdata !== 32'h0 || o_hold_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_rsp: got err=%b tmo=%b rdata=%h hold=%b, want 1/1/0/1", o_err, o_tmo, o_rdata, o_hold_ok);
        end
        do_txn(1'b0, 4'hF, 32'h4000_000C, 32'h0, 32'h1357_9BDF, 1'b0, 1, 1, 0, 0);
        n_cmp++;
        if (o_tmo !== 1'b0 || o_rdata !== 32'h1357_9BDF || o_lat !== 3) begin
            n_bad++;
            $display("FAIL timeout_recover: got tmo=%b rdata=%h lat=%0d, want 0/13579bdf/3", o_tmo, o_rdata, o_lat);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dbg.cmd_valid = 0; dbg.cmd_we = 0; dbg.cmd_be = 0; dbg.cmd_addr = 0; dbg.cmd_wdata = 0;
        dbg.rsp_ready = 0; dbg.data_gnt = 0; dbg.data_rvalid = 0; dbg.data_rdata = 0; dbg.data_err = 0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_error();
        test_hold();
        test_gnt_delay();
        test_same_cycle();
        test_random();
        test_reset_mid();
`ifdef DBGBUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
